// File: rtl/vscale_dmem_arbiter.sv
// vscale_dmem_arbiter: round-robin sharing of one two-phase data-memory port
// among NUM_CORES vscale pipelines. Address and data phases overlap so
// back-to-back grants sustain one access per cycle.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   core_dmem_*         : per-core dmem ports (slice i belongs to core i)
//   core_dmem_wait      : per-core stall (lost arbitration or data phase stalled)
//   core_dmem_rdata     : memory read data broadcast to all cores
//   core_dmem_badmem_e  : bad-access flag routed to the data-phase owner
//   mem_*               : shared memory port
//   grant_id            : core granted this cycle (rr_ptr when idle)

`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module vscale_dmem_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned CORE_IDX_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CORES-1:0]                   core_dmem_en,
    input  logic [NUM_CORES-1:0]                   core_dmem_wen,
    input  logic [NUM_CORES*`MEM_TYPE_WIDTH-1:0]   core_dmem_size,
    input  logic [NUM_CORES*`XPR_LEN-1:0]          core_dmem_addr,
    input  logic [NUM_CORES*`XPR_LEN-1:0]          core_dmem_wdata,
    output logic [NUM_CORES-1:0]                   core_dmem_wait,
    output logic [`XPR_LEN-1:0]                    core_dmem_rdata,
    output logic [NUM_CORES-1:0]                   core_dmem_badmem_e,
    output logic                                   mem_en,
    output logic                                   mem_wen,
    output logic [`MEM_TYPE_WIDTH-1:0]             mem_size,
    output logic [`XPR_LEN-1:0]                    mem_addr,
    output logic [`XPR_LEN-1:0]                    mem_wdata,
    input  logic                                   mem_wait,
    input  logic [`XPR_LEN-1:0]                    mem_rdata,
    input  logic                                   mem_badmem_e,
    output logic [CORE_IDX_WIDTH-1:0]              grant_id
);

    localparam int unsigned MW = `MEM_TYPE_WIDTH;
    localparam int unsigned XW = `XPR_LEN;
    localparam logic [CORE_IDX_WIDTH-1:0] LAST_IDX = CORE_IDX_WIDTH'(NUM_CORES - 1);

    logic [CORE_IDX_WIDTH-1:0] rr_ptr;
    logic                      dph_valid;
    logic [CORE_IDX_WIDTH-1:0] dph_owner;

    logic                      grant_any;
    logic [CORE_IDX_WIDTH-1:0] grant_idx;
    logic [CORE_IDX_WIDTH-1:0] cand;
    logic [CORE_IDX_WIDTH-1:0] rr_next;

    logic [MW-1:0] size_arr  [NUM_CORES];
    logic [XW-1:0] addr_arr  [NUM_CORES];
    logic [XW-1:0] wdata_arr [NUM_CORES];

    // Unpack per-core slices for indexed selection.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign size_arr[i]  = core_dmem_size[i*MW +: MW];
        assign addr_arr[i]  = core_dmem_addr[i*XW +: XW];
        assign wdata_arr[i] = core_dmem_wdata[i*XW +: XW];
    end

    // Round-robin scan starting at rr_ptr, wrapping at NUM_CORES.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = CORE_IDX_WIDTH'((32'(rr_ptr) + k) % NUM_CORES);
            if (!mem_wait && !grant_any && core_dmem_en[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + CORE_IDX_WIDTH'(1);
    end

    // Arbiter state; everything holds while memory stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            dph_valid <= 1'b0;
            dph_owner <= '0;
        end else if (!mem_wait) begin
            dph_valid <= grant_any;
            dph_owner <= grant_idx;
            if (grant_any) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Address-phase mux, data-phase routing and per-core stalls.
    always_comb begin
        mem_en             = 1'b0;
        mem_wen            = 1'b0;
        grant_id           = '0;
        mem_wdata          = '0;
        core_dmem_wait     = '0;
        core_dmem_badmem_e = '0;
        mem_size           = size_arr[grant_idx];
        mem_addr           = addr_arr[grant_idx];
        if (!reset) begin
            mem_en   = grant_any;
            mem_wen  = grant_any & core_dmem_wen[grant_idx];
            grant_id = grant_idx;
            if (dph_valid) begin
                mem_wdata = wdata_arr[dph_owner];
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                core_dmem_wait[i] =
                    (core_dmem_en[i] & ~(grant_any & (grant_idx == CORE_IDX_WIDTH'(i)))) |
                    (dph_valid & (dph_owner == CORE_IDX_WIDTH'(i)) & mem_wait);
                core_dmem_badmem_e[i] =
                    dph_valid & (dph_owner == CORE_IDX_WIDTH'(i)) & mem_badmem_e;
            end
        end
    end

    assign core_dmem_rdata = mem_rdata;

    // A stalled requester must hold its address-phase signals.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_hold
        a_hold : assert property (@(posedge clk) disable iff (reset)
            (core_dmem_wait[i] && core_dmem_en[i]) |=>
            (core_dmem_en[i] && $stable(core_dmem_wen[i]) &&
             $stable(size_arr[i]) && $stable(addr_arr[i])));
    end

endmodule

// File: doc/vscale_dmem_arbiter.md
Name: vscale_dmem_arbiter

Overview:
- Shares one data-memory port among NUM_CORES vscale pipelines using round-robin arbitration.
- Protocol is two-phase on both sides. Address phase carries en/wen/size/addr; data phase is the next accepted cycle and carries write data in and read data out.
- Address and data phases overlap, so back-to-back grants to different cores sustain one access per cycle.
- Sits between the per-core dmem ports and the shared memory/interconnect.

Parameters:
- NUM_CORES, 4, number of requesting cores; legal range 2..4.
- CORE_IDX_WIDTH, 2, width of the core index; must satisfy 2**CORE_IDX_WIDTH >= NUM_CORES.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- core_dmem_en  input  NUM_CORES  per-core address-phase request
- core_dmem_wen  input  NUM_CORES  per-core write enable
- core_dmem_size  input  NUM_CORES*`MEM_TYPE_WIDTH  per-core access size; slice i belongs to core i
- core_dmem_addr  input  NUM_CORES*`XPR_LEN  per-core address
- core_dmem_wdata  input  NUM_CORES*`XPR_LEN  per-core write data, valid in data phase
- core_dmem_wait  output  NUM_CORES  per-core stall
- core_dmem_rdata  output  `XPR_LEN  read data, broadcast to all cores
- core_dmem_badmem_e  output  NUM_CORES  per-core bad-access flag, data phase
- mem_en  output  1  shared address-phase request
- mem_wen  output  1  shared write enable
- mem_size  output  `MEM_TYPE_WIDTH  shared access size
- mem_addr  output  `XPR_LEN  shared address
- mem_wdata  output  `XPR_LEN  shared write data, data phase
- mem_wait  input  1  memory stall
- mem_rdata  input  `XPR_LEN  memory read data
- mem_badmem_e  input  1  memory bad-access flag
- grant_id  output  CORE_IDX_WIDTH  index of the core granted this cycle; debug/assertions

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.

State:
- rr_ptr: CORE_IDX_WIDTH bits, the highest-priority core index.
- dph_valid: 1 bit, data phase in progress.
- dph_owner: CORE_IDX_WIDTH bits, core that owns the data phase.

Reset:
- Registers: rr_ptr=0, dph_valid=0, dph_owner=0.
- While reset is high, all outputs are forced to 0: mem_en, mem_wen, core_dmem_wait, core_dmem_badmem_e, grant_id.

Arbitration (combinational, same cycle):
- If mem_wait=1, nothing is granted.
- Otherwise grant the first core i with core_dmem_en[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
- Wrap uses NUM_CORES, not 2**CORE_IDX_WIDTH.

Memory outputs on a grant to core g:
- mem_en=1.
- mem_wen, mem_size, mem_addr are core g's slices.
- grant_id=g.

Memory outputs with no grant:
- mem_en=0, mem_wen=0, grant_id=rr_ptr.
- mem_size and mem_addr are don't-care; drive them from the rr_ptr slice.

Per-core wait:
- core_dmem_wait[i] = (core_dmem_en[i] & ~granted_i) | (dph_valid & dph_owner==i & mem_wait).
- A waiting core holds en/wen/size/addr stable. Stability is checked only by assertion.

Sequential update on each rising edge, when mem_wait=0:
- dph_valid <= grant_any; dph_owner <= g.
- If grant_any, rr_ptr <= (g+1) mod NUM_CORES; otherwise rr_ptr is unchanged.

Sequential update when mem_wait=1:
- All state holds.

Data phase:
- mem_wdata = core_dmem_wdata slice of dph_owner, or 0 when dph_valid=0.
- core_dmem_rdata = mem_rdata, passed through combinationally.
- core_dmem_badmem_e[i] = dph_valid & dph_owner==i & mem_badmem_e.

Latency:
- An uncontended request is granted in the same cycle, with zero added wait.
- A contended request waits at most NUM_CORES-1 grant cycles while mem_wait=0.

Simultaneous events:
- A core in its data phase may also present a new address-phase request. It is eligible for that grant like any other core.
- Back-to-back grants to the same core occur only when no other core requests.

Reset mid-operation:
- Any in-flight data phase is dropped; no write data reaches memory after reset is asserted.

No request ever starves:
- Once granted, a core becomes lowest priority.

Test Plan:
- Reset, then core 1 alone requests a read at addr 0x40 with mem_wait=0. Expect mem_en=1, mem_addr=0x40, grant_id=1, core_dmem_wait=0000. Next cycle mem_rdata=0xDEADBEEF appears on core_dmem_rdata, and rr_ptr=2.
- All 4 cores request continuously with rr_ptr=0. Expect grant_id to cycle 0,1,2,3,0. Each non-granted core sees wait=1, and no core waits more than 3 cycles.
- Core 0 writes 0x12345678 to 0x80 while core 2 requests in the following cycle. Expect mem_wdata=0x12345678 in the same cycle core 2's address 0x..., with mem_en=1 and grant_id=2 (phases overlap).
- Core 3 is in its data phase and mem_wait is held high for 3 cycles while core 0 requests. Expect core_dmem_wait[3]=1 and core_dmem_wait[0]=1, mem_en=0, and state held. After release, core 0 is granted with rr_ptr unchanged across the stall.
- Core 2 is in its data phase and mem_badmem_e=1. Expect core_dmem_badmem_e=0100 and no flag on any other core.
- Assert reset during a core 1 write data phase. Expect all outputs 0 while reset is high, and after release dph_valid=0, rr_ptr=0, mem_wdata=0.
